// File: rtl/cv32e40p_instr_obi_arbiter.sv
// Two-requester round-robin arbiter onto one OBI instruction memory port.
// Latency: grant and response are combinational pass-throughs (0 cycles added).
// Backpressure: the memory port is held off while DEPTH transactions are outstanding.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   m0_*/m1_*             requester-side OBI (req/addr in; gnt/rvalid/rdata/err out)
//   s_*                   memory-side OBI (req/addr out; gnt/rvalid/rdata/err in)
//   busy_o                high while any granted transaction awaits its response
module cv32e40p_instr_obi_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        s_req_o,
  output logic [31:0] s_addr_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  input  logic        s_err_i,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Round-robin pointer (0 = m0 has priority) and OBI stability lock.
  logic ptr_q, ptr_d;
  logic lock_q, lock_d;
  logic owner_q, owner_d;

  // In-order ID FIFO: one bit per outstanding transaction naming its requester.
  logic [DEPTH-1:0] id_q, id_d;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic        sel;
  logic        sel_req;
  logic        full, empty;
  logic        accept, pop;
  logic        head;
  logic        owner_req;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign owner_req = owner_q ? m1_req_i : m0_req_i;

  always_comb begin
    sel = ptr_q;
    if (lock_q) begin
      sel = owner_q;
    end else if (m0_req_i && !m1_req_i) begin
      sel = 1'b0;
    end else if (m1_req_i && !m0_req_i) begin
      sel = 1'b1;
    end
  end

  assign sel_req  = sel ? m1_req_i : m0_req_i;
  // No bypass at full: a same-cycle pop does not free a slot until next cycle.
  assign s_req_o  = sel_req && !full;
  assign s_addr_o = sel_req ? (sel ? m1_addr_i : m0_addr_i) : 32'h0;
  assign accept   = s_req_o && s_gnt_i;
  assign m0_gnt_o = accept && !sel;
  assign m1_gnt_o = accept && sel;

  // A response with nothing outstanding is dropped rather than routed.
  assign pop         = s_rvalid_i && !empty;
  assign head        = id_q[rd_q];
  assign m0_rvalid_o = pop && !head;
  assign m1_rvalid_o = pop && head;
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : 32'h0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : 32'h0;
  assign m0_err_o    = m0_rvalid_o && s_err_i;
  assign m1_err_o    = m1_rvalid_o && s_err_i;
  assign busy_o      = !empty;

  always_comb begin
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    if (accept) begin
      ptr_d  = !sel;
      lock_d = 1'b0;
    end else if (s_req_o) begin
      // Ungranted request: freeze the selection so the address cannot change.
      lock_d  = 1'b1;
      owner_d = sel;
    end else if (lock_q && !owner_req) begin
      lock_d = 1'b0;
    end
  end

  always_comb begin
    id_d = id_q;
    wr_d = wr_q;
    rd_d = rd_q;
    if (accept) begin
      id_d[wr_q] = sel;
      wr_d       = nxt(wr_q);
    end
    if (pop) begin
      rd_d = nxt(rd_q);
    end
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= 1'b0;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      id_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      id_q    <= id_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (s_req_o && !s_gnt_i) |=> (!s_req_o || $stable(s_addr_o)));
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CW'(DEPTH));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(m0_gnt_o && m1_gnt_o));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(m0_rvalid_o && m1_rvalid_o));
  // Requester-side and memory-side protocol violations are reported, not fatal.
  a_lock_owner_held: assert property (@(posedge clk) disable iff (!rst_n)
    !(lock_q && !owner_req))
    else $warning("lock owner dropped its request before grant");
  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    !(s_rvalid_i && empty))
    else $warning("memory response with no outstanding transaction");
`endif

endmodule

// File: tb/tb_cv32e40p_instr_obi_arbiter.sv
module tb_cv32e40p_instr_obi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
  logic [31:0] m0_addr_i = 32'h0, m1_addr_i = 32'h0;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
  logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o;
  logic [31:0] s_addr_o;
  logic        s_gnt_i = 1'b0, s_rvalid_i = 1'b0, s_err_i = 1'b0;
  logic [31:0] s_rdata_i = 32'h0;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40p_instr_obi_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_gnt_i(s_gnt_i),
    .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
    .busy_o(busy_o)
  );

  // Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic r1, input logic g,
                       input logic rv, input logic [31:0] rd, input logic er);
    m0_req_i = r0; m1_req_i = r1; s_gnt_i = g;
    s_rvalid_i = rv; s_rdata_i = rd; s_err_i = er;
    #1;
  endtask

  task automatic do_reset;
    tick;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 0);
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 0);
    checks++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL reset_sreq got %b want 0", s_req_o); end
    checks++; if (s_addr_o !== 32'h0) begin errors++; $display("FAIL reset_saddr got %h want 0", s_addr_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !== 4'b0) begin errors++; $display("FAIL reset_mout got %b want 0000", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o}); end
    tick;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 0);
    checks++; if (busy_o !== 1'b0 || s_req_o !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b sreq=%b want 0 0", busy_o, s_req_o); end
  endtask

  task automatic test_single;
    do_reset;
    m0_addr_i = 32'h1000; m1_addr_i = 32'h2000;
    drive(1, 0, 1, 0, 32'h0, 0);
    checks++; if (s_req_o !== 1'b1 || s_addr_o !== 32'h1000) begin errors++; $display("FAIL single_req sreq=%b addr=%h want 1 00001000", s_req_o, s_addr_o); end
    checks++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin errors++; $display("FAIL single_gnt got m0=%b m1=%b want 1 0", m0_gnt_o, m1_gnt_o); end
    tick;
    drive(0, 0, 0, 1, 32'hDEADBEEF, 0);
    checks++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rsp got rv=%b data=%h want 1 deadbeef", m0_rvalid_o, m0_rdata_o); end
    checks++; if (m1_rvalid_o !== 1'b0 || m1_rdata_o !== 32'h0 || m1_err_o !== 1'b0) begin errors++; $display("FAIL single_m1 got rv=%b data=%h err=%b want 0 0 0", m1_rvalid_o, m1_rdata_o, m1_err_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy_o); end
    tick;
    drive(0, 0, 0, 0, 32'h0, 0);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", busy_o); end
  endtask

  task automatic test_contention;
    // bit k set = cycle k grants m1; responses trail grants by one cycle.
    logic [5:0] exp_m1 = 6'b101010;
    do_reset;
    m0_addr_i = 32'h100; m1_addr_i = 32'h200;
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 1, k > 0, 32'hA000 + k, 0);
      checks++; if (m1_gnt_o !== exp_m1[k] || m0_gnt_o !== !exp_m1[k]) begin errors++; $display("FAIL cont_gnt%0d got m0=%b m1=%b want %b %b", k, m0_gnt_o, m1_gnt_o, !exp_m1[k], exp_m1[k]); end
      checks++; if (s_addr_o !== (exp_m1[k] ? 32'h200 : 32'h100)) begin errors++; $display("FAIL cont_addr%0d got %h", k, s_addr_o); end
      if (k > 0) begin
        checks++; if (m1_rvalid_o !== exp_m1[k-1] || m0_rvalid_o !== !exp_m1[k-1]) begin errors++; $display("FAIL cont_rv%0d got m0=%b m1=%b want %b %b", k, m0_rvalid_o, m1_rvalid_o, !exp_m1[k-1], exp_m1[k-1]); end
        checks++; if ((exp_m1[k-1] ? m1_rdata_o : m0_rdata_o) !== 32'hA000 + k) begin errors++; $display("FAIL cont_data%0d got %h want %h", k, exp_m1[k-1] ? m1_rdata_o : m0_rdata_o, 32'hA000 + k); end
      end
      tick;
    end
    drive(0, 0, 0, 1, 32'hA006, 0);
    checks++; if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'hA006) begin errors++; $display("FAIL cont_last got rv=%b data=%h want 1 0000a006", m1_rvalid_o, m1_rdata_o); end
    tick;
    drive(0, 0, 0, 0, 32'h0, 0);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL cont_idle got %b want 0", busy_o); end
  endtask

  task automatic test_lock;
    do_reset;
    m0_addr_i = 32'h100; m1_addr_i = 32'h200;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 0, 32'h0, 0);
      checks++; if (s_req_o !== 1'b1 || s_addr_o !== 32'h100 || m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin errors++; $display("FAIL lock_hold%0d sreq=%b addr=%h gnt=%b%b want 1 100 00", k, s_req_o, s_addr_o, m0_gnt_o, m1_gnt_o); end
      tick;
    end
    drive(1, 1, 1, 0, 32'h0, 0);
    checks++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin errors++; $display("FAIL lock_gnt got m0=%b m1=%b want 1 0", m0_gnt_o, m1_gnt_o); end
    tick;
    drive(1, 1, 1, 0, 32'h0, 0);
    checks++; if (m1_gnt_o !== 1'b1 || m0_gnt_o !== 1'b0) begin errors++; $display("FAIL lock_next got m0=%b m1=%b want 0 1", m0_gnt_o, m1_gnt_o); end
    // m1 waits alone; m0 then arrives while the pointer favours m0.
    do_reset;
    drive(0, 1, 0, 0, 32'h0, 0);
    checks++; if (s_addr_o !== 32'h200) begin errors++; $display("FAIL lock2_first got %h want 00000200", s_addr_o); end
    tick;
    drive(1, 1, 0, 0, 32'h0, 0);
    checks++; if (s_addr_o !== 32'h200) begin errors++; $display("FAIL lock2_hold got %h want 00000200", s_addr_o); end
    tick;
    drive(1, 1, 1, 0, 32'h0, 0);
    checks++; if (m1_gnt_o !== 1'b1 || m0_gnt_o !== 1'b0) begin errors++; $display("FAIL lock2_gnt got m0=%b m1=%b want 0 1", m0_gnt_o, m1_gnt_o); end
    tick;
    drive(1, 1, 1, 0, 32'h0, 0);
    checks++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin errors++; $display("FAIL lock2_next got m0=%b m1=%b want 1 0", m0_gnt_o, m1_gnt_o); end
    tick;
  endtask

  task automatic test_full;
    do_reset;
    m0_addr_i = 32'h100; m1_addr_i = 32'h200;
    drive(1, 1, 1, 0, 32'h0, 0);
    checks++; if (m0_gnt_o !== 1'b1) begin errors++; $display("FAIL full_g0 got %b want 1", m0_gnt_o); end
    tick;
    drive(1, 1, 1, 0, 32'h0, 0);
    checks++; if (m1_gnt_o !== 1'b1) begin errors++; $display("FAIL full_g1 got %b want 1", m1_gnt_o); end
    tick;
    drive(0, 1, 1, 0, 32'h0, 0);
    checks++; if (s_req_o !== 1'b0 || m1_gnt_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL full_block sreq=%b gnt=%b busy=%b want 0 0 1", s_req_o, m1_gnt_o, busy_o); end
    tick;
    drive(0, 1, 1, 1, 32'h11, 0);
    checks++; if (s_req_o !== 1'b0 || m1_gnt_o !== 1'b0) begin errors++; $display("FAIL full_nobypass sreq=%b gnt=%b want 0 0", s_req_o, m1_gnt_o); end
    checks++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h11) begin errors++; $display("FAIL full_rsp rv=%b data=%h want 1 00000011", m0_rvalid_o, m0_rdata_o); end
    tick;
    drive(0, 1, 1, 0, 32'h0, 0);
    checks++; if (s_req_o !== 1'b1 || m1_gnt_o !== 1'b1 || s_addr_o !== 32'h200) begin errors++; $display("FAIL full_resume sreq=%b gnt=%b addr=%h want 1 1 200", s_req_o, m1_gnt_o, s_addr_o); end
    tick;
  endtask

  task automatic test_out_of_phase;
    do_reset;
    m0_addr_i = 32'h300; m1_addr_i = 32'h400;
    drive(1, 0, 1, 0, 32'h0, 0);
    checks++; if (m0_gnt_o !== 1'b1) begin errors++; $display("FAIL oop_g0 got %b want 1", m0_gnt_o); end
    tick;
    drive(0, 1, 1, 0, 32'h0, 0);
    checks++; if (m1_gnt_o !== 1'b1) begin errors++; $display("FAIL oop_g1 got %b want 1", m1_gnt_o); end
    tick;
    drive(0, 0, 0, 1, 32'hA0, 0);
    checks++; if (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0 || m0_err_o !== 1'b0) begin errors++; $display("FAIL oop_r0 rv=%b%b err=%b want 10 0", m0_rvalid_o, m1_rvalid_o, m0_err_o); end
    tick;
    drive(1, 0, 1, 1, 32'hA1, 1);
    checks++; if (m0_gnt_o !== 1'b1) begin errors++; $display("FAIL oop_g2 got %b want 1", m0_gnt_o); end
    checks++; if (m1_rvalid_o !== 1'b1 || m1_err_o !== 1'b1 || m1_rdata_o !== 32'hA1 || m0_rvalid_o !== 1'b0 || m0_err_o !== 1'b0) begin errors++; $display("FAIL oop_r1 m1 rv=%b err=%b data=%h m0 rv=%b err=%b", m1_rvalid_o, m1_err_o, m1_rdata_o, m0_rvalid_o, m0_err_o); end
    tick;
    drive(0, 0, 0, 1, 32'hA2, 0);
    checks++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hA2 || m0_err_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL oop_r2 rv=%b data=%h err=%b busy=%b", m0_rvalid_o, m0_rdata_o, m0_err_o, busy_o); end
    tick;
    drive(0, 0, 0, 0, 32'h0, 0);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL oop_idle got %b want 0", busy_o); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    m0_addr_i = 32'h500; m1_addr_i = 32'h600;
    drive(1, 1, 1, 0, 32'h0, 0);
    tick;
    drive(1, 1, 1, 0, 32'h0, 0);
    tick;
    drive(0, 0, 0, 0, 32'h0, 0);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b want 1", busy_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmid_async got %b want 0", busy_o); end
    tick;
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 32'h77, 1);
    checks++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0 || m0_rdata_o !== 32'h0 || m1_err_o !== 1'b0) begin errors++; $display("FAIL rmid_spurious rv=%b%b data=%h err=%b want 00 0 0", m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_err_o); end
    tick;
    drive(1, 1, 1, 0, 32'h0, 0);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmid_cnt got busy=%b want 0", busy_o); end
    checks++; if (m0_gnt_o !== 1'b1 || s_addr_o !== 32'h500) begin errors++; $display("FAIL rmid_ptr gnt=%b addr=%h want 1 00000500", m0_gnt_o, s_addr_o); end
    tick;
    drive(0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_lock;
    test_full;
    test_out_of_phase;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
